dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the npc core: the slave end of the load/store path that the execute stage drives.
- Accepts one word-wide read or byte-masked write request at a time over a valid/ready request channel.
- Performs the access after a configurable latency and returns a response over a valid/ready response channel.
- Replaces direct combinational memory calls with a cycle-accurate, handshaked memory model.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words backed by the array (power of two).
- LATENCY, 2, cycles from request handshake to first rsp_valid cycle; legal range 1..15.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data, lane-aligned (byte k in bits [8k+7:8k]).
- req_wmask  in  4  store byte-lane enables; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data (full word); 0 for stores and errors.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - req_ready=0 while rst_n=0, and 1 in the first cycle after reset release.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch wen, word offset, wdata and wmask, and load counter=LATENCY-1.
  - If LATENCY-1==0, perform the access at that same edge and go to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0. The counter decrements every cycle.
  - At the edge where the counter equals 1, perform the access and go to RESP.
  - With the handshake in cycle 0, rsp_valid is first high in cycle LATENCY.
- Access:
  - Offset = req_addr - BASE_ADDR, computed in 32 bits unsigned; it is in range iff offset < 4*DEPTH_WORDS.
  - Word index = offset[log2(4*DEPTH_WORDS)-1:2].
  - Store in range: write only the lanes whose wmask bit is set. wmask=0 writes nothing but still responds. rdata=0, err=0.
  - Load in range: rdata = array word, err=0.
  - Out of range: no array change, rdata=0, err=1.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge go to IDLE; rsp_valid=0 in the next cycle. No request is accepted in the response-handshake cycle.
- Ordering: one outstanding request. A load accepted after a store response sees the stored bytes.
- Reset mid-operation:
  - In WAIT, a pending store whose access edge has not yet occurred is dropped.
  - In RESP, the response is discarded.
- Address wrap: addresses below BASE_ADDR wrap to a large offset and flag err. There is no modulo aliasing.
- Request inputs are sampled only on the handshake edge; changes in WAIT or RESP have no effect.

Decomposition:
- dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - XLEN=32, MASK_W=4.
  - Helper function for lane merge (old word, new word, mask).
- One sub-module, dmem_array: synchronous single-port word RAM with a 4-bit byte-write enable and registered read data captured on the access edge. The FSM, counter and address check stay in dmem_responder.

Test Plan:
- Reset release, then store addr=0x8000_0010, wdata=0xDEADBEEF, wmask=0xF with LATENCY=2 and rsp_ready=1:
  - rsp_valid rises exactly 2 cycles after the handshake cycle, rdata=0, err=0.
  - A following load from the same address returns 0xDEADBEEF.
- Byte store addr=0x8000_0010, wdata=0x0000_00AA, wmask=0x1 over 0xDEADBEEF -> a load returns 0xDEADBEAA. Then store wdata=0x1200_0000, wmask=0x8 -> a load returns 0x12ADBEAA.
- Backpressure: load with rsp_ready=0 for 5 cycles:
  - rsp_valid stays 1 with rdata stable.
  - req_ready=0 throughout.
  - req_valid held high is not accepted until the cycle after the rsp handshake.
- Out of range: load at 0x7FFF_FFFC and store at 0x8000_1000 (DEPTH_WORDS=1024) -> err=1, rdata=0, and no array word changes (verified by reading word 1023 and word 0).
- LATENCY=1: handshake in cycle 0 -> rsp_valid in cycle 1. Back-to-back loads with rsp_ready=1 are accepted every 2 cycles.
- Reset mid-WAIT: store to 0x8000_0020 (LATENCY=4), rst_n=0 in cycle 2 -> rsp_valid never asserts, and a later load from 0x8000_0020 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and lane-merge helper for the data-memory responder
package dmem_pkg;
  localparam int XLEN = 32;
  localparam int MASK_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] old_w, input logic [XLEN-1:0] new_w, input logic [MASK_W-1:0] mask);
    logic [XLEN-1:0] r;
    r = old_w;
    for (int i = 0; i < MASK_W; i++) r[8*i+:8] = mask[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with byte-write enables and registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [MASK_W-1:0]        wmask,
  output logic [XLEN-1:0]          rdata
);
  logic [XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (wen) mem[addr] <= lane_merge(mem[addr], wdata, wmask);
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory slave with fixed access latency and range check
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  state_t state, nxt;
  logic [3:0] cnt;
  logic wen_q, err_q, hs, now, acc, a_wen;
  logic [AW-1:0] idx_q, a_idx;
  logic [XLEN-1:0] wdata_q, a_wdata, rd;
  logic [MASK_W-1:0] wmask_q, a_wmask;
  logic [31:0] off;
  assign off = req_addr - BASE_ADDR;
  assign req_ready = rst_n && state == IDLE;
  assign hs = req_valid && req_ready;
  assign now = state == IDLE;
  assign acc = rst_n && ((hs && LATENCY == 1) || (state == WAIT && cnt == 4'd1)) && !(now ? off >= SPAN : err_q);
  assign a_wen = now ? req_wen : wen_q;
  assign a_idx = now ? off[AW+1:2] : idx_q;
  assign a_wdata = now ? req_wdata : wdata_q;
  assign a_wmask = now ? req_wmask : wmask_q;
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid && !wen_q && !err_q ? rd : '0;
  always_comb
    nxt = state == IDLE ? (hs ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
        : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
        : (rsp_ready ? IDLE : RESP);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      wen_q <= 1'b0;
      err_q <= 1'b0;
    end else if (hs) begin
      cnt <= 4'(LATENCY - 1);
      wen_q <= req_wen;
      err_q <= off >= SPAN;
      idx_q <= off[AW+1:2];
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end else if (state == WAIT) cnt <= cnt - 4'd1;
  dmem_array #(.DEPTH(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .en   (acc),
    .wen  (a_wen),
    .addr (a_idx),
    .wdata(a_wdata),
    .wmask(a_wmask),
    .rdata(rd)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of three responders against a word-array model
module tb_dmem_responder;
  localparam logic [31:0] B = 32'h8000_0000;
  function automatic int lat_of(input int k);
    return k == 0 ? 2 : (k == 1 ? 1 : 4);
  endfunction
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [3];
  logic req_valid [3];
  logic rsp_ready [3];
  logic req_ready [3];
  logic rsp_valid [3];
  logic rsp_err [3];
  logic [31:0] rsp_rdata [3];
  logic req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_wmask;
  logic [31:0] model [3][1024];
  time hs_t [3];
  int total = 0;
  int bad = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.LATENCY(lat_of(g))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wen  (req_wen),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_wmask(req_wmask),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input int bp, input logic hold);
    logic [31:0] off, er;
    logic in_r;
    logic [9:0] idx;
    int n;
    off = a - B;
    in_r = off < 32'd4096;
    idx = off[11:2];
    er = (!w && in_r) ? model[k][idx] : 32'h0;
    if (w && in_r)
      for (int b = 0; b < 4; b++) if (m[b]) model[k][idx][8*b+:8] = d[8*b+:8];
    req_wen = w;
    req_addr = a;
    req_wdata = d;
    req_wmask = m;
    req_valid[k] = 1'b1;
    rsp_ready[k] = 1'b1;
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    step;
    hs_t[k] = $time;
    req_valid[k] = 1'b0;
    req_wen = 1'b1;
    req_addr = B + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    req_wdata = $urandom;
    req_wmask = 4'hF;
    n = 1;
    while (!rsp_valid[k] && n < 20) begin
      chk("req_ready_wait", 32'(req_ready[k]), 32'd0);
      step;
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of(k)));
    chk("rsp_err", 32'(rsp_err[k]), 32'(!in_r));
    chk("rsp_rdata", rsp_rdata[k], er);
    if (bp > 0) begin
      rsp_ready[k] = 1'b0;
      req_valid[k] = hold;
      for (int i = 0; i < bp; i++) begin
        step;
        chk("bp_valid", 32'(rsp_valid[k]), 32'd1);
        chk("bp_rdata", rsp_rdata[k], er);
        chk("bp_req_ready", 32'(req_ready[k]), 32'd0);
      end
      rsp_ready[k] = 1'b1;
    end
    step;
    chk("rsp_valid_drop", 32'(rsp_valid[k]), 32'd0);
    chk("req_ready_back", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b0;
  endtask
  initial begin
    time prev;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    req_wen = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wmask = '0;
    repeat (3) step;
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
      chk("rst_err", 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++) chk("release_req_ready", 32'(req_ready[k]), 32'd1);
    txn(0, 1'b1, B + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    txn(0, 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, B + 32'h10, 32'h0000_00AA, 4'h1, 0, 1'b0);
    txn(0, 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, B + 32'h10, 32'h1200_0000, 4'h8, 0, 1'b0);
    txn(0, 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, B + 32'h10, 32'h5555_5555, 4'h0, 0, 1'b0);
    txn(0, 1'b0, B + 32'h10, 32'h0, 4'h0, 5, 1'b1);
    txn(0, 1'b1, B + 32'hFFC, 32'h1122_3344, 4'hF, 0, 1'b0);
    txn(0, 1'b1, B, 32'h5566_7788, 4'hF, 0, 1'b0);
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, B + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
    txn(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
    txn(0, 1'b0, B + 32'hFFC, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b0, B, 32'h0, 4'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) txn(1, 1'b1, B + 32'(4 * i), $urandom, 4'hF, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      prev = hs_t[1];
      txn(1, 1'b0, B + 32'(4 * i), 32'h0, 4'h0, 0, 1'b0);
      chk("b2b_spacing", 32'(hs_t[1] - prev), 32'd20);
    end
    txn(2, 1'b1, B + 32'h20, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    req_wen = 1'b1;
    req_addr = B + 32'h20;
    req_wdata = 32'h0BAD_BEEF;
    req_wmask = 4'hF;
    req_valid[2] = 1'b1;
    step;
    req_valid[2] = 1'b0;
    step;
    rst_n[2] = 1'b0;
    step;
    chk("midwait_rst_valid", 32'(rsp_valid[2]), 32'd0);
    chk("midwait_rst_ready", 32'(req_ready[2]), 32'd0);
    step;
    rst_n[2] = 1'b1;
    #1;
    chk("midwait_release_ready", 32'(req_ready[2]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step;
      chk("midwait_no_rsp", 32'(rsp_valid[2]), 32'd0);
    end
    txn(2, 1'b0, B + 32'h20, 32'h0, 4'h0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) txn(k, 1'b1, B + 32'(4 * i), $urandom, 4'hF, 0, 1'b0);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 7) == 0)
          a = $urandom_range(0, 1) == 1 ? B + 32'h1000 + 32'(4 * $urandom_range(0, 255)) : B - 32'(4 * (1 + $urandom_range(0, 255)));
        else
          a = B + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
